alarm_controller: RTL and testbench

Front end of the home alarm system: synchronizes and debounces four raw zone sensors and the arm/disarm buttons, runs the arm/exit/entry/alarm state machine, and drives the 5-bit status bus consumed by the seven-segment display block. The bus carries {armed, tripped_zones[3:0]}. The display shows `0` when disarmed, `A` when armed with no trips, and the tripped-zone count otherwise. The block also drives the siren output.

---
 rtl/alarm_pkg.sv | 16 +
 rtl/alarm_controller_input_debouncer.sv | 43 ++++
 rtl/alarm_controller.sv | 76 +++++++
 tb/tb_alarm_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: state encodings, zone count and status bus layout shared by the alarm and display blocks
package alarm_pkg;
  localparam int ZONES = 4;
  localparam int STATUS_W = ZONES + 1;
  localparam int ST_ARMED = ZONES;
  localparam int ST_ZONE_MSB = ZONES - 1;
  localparam int ST_ZONE_LSB = 0;
  localparam int TIMER_W = 30;
  typedef enum logic [2:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4
  } state_t;
endpackage

// File: rtl/alarm_controller_input_debouncer.sv
// input_debouncer: 2-flop synchronizer, stable-count debouncer and optional registered rising-edge pulse
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          PULSE_EN        = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic differ, done;
  assign differ = sync[1] != level;
  assign done = differ && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      cnt   <= (!differ || done) ? '0 : cnt + 1'b1;
      level <= done ? sync[1] : level;
    end
  end
  if (PULSE_EN) begin : g_pulse
    logic prev;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev  <= 1'b0;
        pulse <= 1'b0;
      end else begin
        prev  <= level;
        pulse <= level & ~prev;
      end
    end
  end else begin : g_nopulse
    assign pulse = 1'b0;
  end
endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: debounced sensor/button front end and arm/exit/entry/alarm FSM; ALARM_ENTRY_DELAY_EN enables the entry delay
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = 1_000_000,
  parameter int unsigned EXIT_DELAY_CYCLES  = 1_000_000_000,
  parameter int unsigned ENTRY_DELAY_CYCLES = 1_000_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ZONES-1:0]    sensor,
  input  logic                arm_btn,
  input  logic                disarm_btn,
  output logic [STATUS_W-1:0] status,
  output logic                siren,
  output logic [2:0]          state_dbg
);
  logic [ZONES-1:0] zone_db, unused_zone_pulse;
  logic arm_p, disarm_p, unused_arm_lvl, unused_disarm_lvl;
  for (genvar i = 0; i < ZONES; i++) begin : g_zone
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PULSE_EN(1'b0)) u_db (
      .clk, .rst_n, .raw(sensor[i]), .level(zone_db[i]), .pulse(unused_zone_pulse[i])
    );
  end
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PULSE_EN(1'b1)) u_arm (
    .clk, .rst_n, .raw(arm_btn), .level(unused_arm_lvl), .pulse(arm_p)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PULSE_EN(1'b1)) u_disarm (
    .clk, .rst_n, .raw(disarm_btn), .level(unused_disarm_lvl), .pulse(disarm_p)
  );
  state_t state, nxt;
  logic [ZONES-1:0] zones, zones_nxt;
  logic [TIMER_W-1:0] timer;
  logic exit_done;
  assign exit_done = timer == TIMER_W'(EXIT_DELAY_CYCLES - 1);
`ifdef ALARM_ENTRY_DELAY_EN
  localparam state_t TRIP = ENTRY_DELAY;
  logic entry_done;
  assign entry_done = timer == TIMER_W'(ENTRY_DELAY_CYCLES - 1);
`else
  localparam state_t TRIP = ALARM;
  localparam int unsigned unused_entry_delay = ENTRY_DELAY_CYCLES;
`endif
  always_comb begin
    nxt = state;
    case (state)
      DISARMED:    nxt = arm_p ? EXIT_DELAY : DISARMED;
      EXIT_DELAY:  nxt = exit_done ? ARMED : EXIT_DELAY;
      ARMED:       nxt = |zone_db ? TRIP : ARMED;
`ifdef ALARM_ENTRY_DELAY_EN
      ENTRY_DELAY: nxt = entry_done ? ALARM : ENTRY_DELAY;
`endif
      ALARM:       nxt = ALARM;
      default:     nxt = DISARMED;
    endcase
    if (disarm_p) nxt = DISARMED;
    zones_nxt = (nxt == DISARMED) ? '0 :
                (state inside {ARMED, ENTRY_DELAY, ALARM}) ? (zones | zone_db) : zones;
  end
  // timer restarts on every state change, so each delay state begins at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DISARMED;
      zones <= '0;
      timer <= '0;
    end else begin
      state <= nxt;
      zones <= zones_nxt;
      timer <= (nxt != state || !(nxt inside {EXIT_DELAY, ENTRY_DELAY})) ? '0 : timer + 1'b1;
    end
  end
  assign status[ST_ARMED] = state != DISARMED;
  assign status[ST_ZONE_MSB:ST_ZONE_LSB] = zones;
  assign siren = state == ALARM;
  assign state_dbg = state;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed self-checking bench for alarm_controller with short debounce/delay parameters
module tb_alarm_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sensor = '0;
  logic arm_btn = 1'b0, disarm_btn = 1'b0;
  logic [4:0] status;
  logic siren;
  logic [2:0] state_dbg;
  int tests = 0, failed = 0;
`ifdef ALARM_ENTRY_DELAY_EN
  localparam logic [2:0] TRIP_ST = 3'd3;
  localparam logic TRIP_SIREN = 1'b0;
`else
  localparam logic [2:0] TRIP_ST = 3'd4;
  localparam logic TRIP_SIREN = 1'b1;
`endif
  alarm_controller #(.DEBOUNCE_CYCLES(4), .EXIT_DELAY_CYCLES(8), .ENTRY_DELAY_CYCLES(6)) dut (
    .clk(clk), .rst_n(rst_n), .sensor(sensor), .arm_btn(arm_btn), .disarm_btn(disarm_btn),
    .status(status), .siren(siren), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic arm_now();
    arm_btn = 1'b1;
    step(8);
    chk("arm_exit_state", 32'(state_dbg), 32'd1);
    step(2);
    arm_btn = 1'b0;
    step(6);
    chk("arm_armed_state", 32'(state_dbg), 32'd2);
    chk("arm_armed_status", 32'(status), 32'b10000);
  endtask
  initial begin
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("rst_status", 32'(status), 32'b00000);
    chk("rst_siren", 32'(siren), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    disarm_btn = 1'b1;
    step(10);
    disarm_btn = 1'b0;
    chk("disarm_idle", 32'(state_dbg), 32'd0);
    step(8);
    arm_btn = 1'b1;
    step(2);
    arm_btn = 1'b0;
    step(10);
    chk("bounce_no_arm", 32'(status), 32'b00000);
    arm_btn = 1'b1;
    step(7);
    chk("press_plus7", 32'(status), 32'b00000);
    step(1);
    chk("press_plus8_status", 32'(status), 32'b10000);
    chk("press_plus8_state", 32'(state_dbg), 32'd1);
    step(2);
    arm_btn = 1'b0;
    step(5);
    chk("exit_last_cycle", 32'(state_dbg), 32'd1);
    step(1);
    chk("exit_done_state", 32'(state_dbg), 32'd2);
    chk("exit_done_status", 32'(status), 32'b10000);
    sensor = 4'b0100;
    step(6);
    chk("trip_pre_state", 32'(state_dbg), 32'd2);
    chk("trip_pre_status", 32'(status), 32'b10000);
    step(1);
    chk("trip_state", 32'(state_dbg), 32'(TRIP_ST));
    chk("trip_status", 32'(status), 32'b10100);
    chk("trip_siren", 32'(siren), 32'(TRIP_SIREN));
`ifdef ALARM_ENTRY_DELAY_EN
    step(5);
    chk("entry_last_state", 32'(state_dbg), 32'd3);
    chk("entry_last_siren", 32'(siren), 32'd0);
    step(1);
    chk("alarm_state", 32'(state_dbg), 32'd4);
    chk("alarm_siren", 32'(siren), 32'd1);
`endif
    sensor = 4'b0101;
    step(6);
    chk("zone0_pre", 32'(status), 32'b10100);
    step(1);
    chk("zone0_latched", 32'(status), 32'b10101);
    arm_btn = 1'b1;
    disarm_btn = 1'b1;
    step(7);
    chk("both_pre_state", 32'(state_dbg), 32'd4);
    step(1);
    chk("both_disarm_state", 32'(state_dbg), 32'd0);
    chk("both_disarm_status", 32'(status), 32'b00000);
    chk("both_disarm_siren", 32'(siren), 32'd0);
    arm_btn = 1'b0;
    disarm_btn = 1'b0;
    sensor = 4'b0000;
    step(10);
    arm_btn = 1'b1;
    step(8);
    chk("preopen_exit", 32'(state_dbg), 32'd1);
    arm_btn = 1'b0;
    sensor = 4'b1000;
    step(7);
    chk("preopen_exit_end_state", 32'(state_dbg), 32'd1);
    chk("preopen_not_latched", 32'(status), 32'b10000);
    step(1);
    chk("preopen_armed_state", 32'(state_dbg), 32'd2);
    chk("preopen_armed_status", 32'(status), 32'b10000);
    step(1);
    chk("preopen_trip_state", 32'(state_dbg), 32'(TRIP_ST));
    chk("preopen_trip_status", 32'(status), 32'b11000);
    disarm_btn = 1'b1;
    sensor = 4'b0000;
    step(8);
    chk("preopen_disarm_state", 32'(state_dbg), 32'd0);
    chk("preopen_disarm_status", 32'(status), 32'b00000);
    disarm_btn = 1'b0;
    step(10);
`ifdef ALARM_ENTRY_DELAY_EN
    arm_now();
    sensor = 4'b0100;
    step(5);
    disarm_btn = 1'b1;
    step(7);
    chk("expiry_race_pre_state", 32'(state_dbg), 32'd3);
    chk("expiry_race_pre_siren", 32'(siren), 32'd0);
    step(1);
    chk("expiry_race_state", 32'(state_dbg), 32'd0);
    chk("expiry_race_status", 32'(status), 32'b00000);
    chk("expiry_race_siren", 32'(siren), 32'd0);
    disarm_btn = 1'b0;
    sensor = 4'b0000;
    step(10);
`endif
    arm_now();
    sensor = 4'b0010;
    step(6);
    chk("z1_pre_state", 32'(state_dbg), 32'd2);
    step(1);
    chk("z1_trip_state", 32'(state_dbg), 32'(TRIP_ST));
    chk("z1_trip_status", 32'(status), 32'b10010);
    chk("z1_trip_siren", 32'(siren), 32'(TRIP_SIREN));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_status", 32'(status), 32'b00000);
    chk("async_rst_siren", 32'(siren), 32'd0);
    chk("async_rst_state", 32'(state_dbg), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
